// File: rtl/ebc_readout_ctrl_pkg.sv
// rtl/ebc_readout_ctrl_pkg.sv - array geometry, readout state encoding and column priority helper
package ebc_readout_ctrl_pkg;

    localparam int ROWS    = 8;
    localparam int COLS    = 8;
    localparam int Y_WIDTH = $clog2(ROWS);
    localparam int X_WIDTH = $clog2(COLS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SCAN,
        ST_ACK,
        ST_DONE
    } ebc_rd_state_t;

    // Lowest-index set bit; the caller guarantees v is non-zero.
    function automatic logic [X_WIDTH-1:0] lowest_col(input logic [COLS-1:0] v);
        logic [X_WIDTH-1:0] idx;
        idx = '0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (v[i]) idx = X_WIDTH'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ebc_readout_ctrl_if.sv
// rtl/ebc_readout_ctrl_if.sv - pixel array request/ack lines and event address stream
interface ebc_readout_ctrl_if;
    import ebc_readout_ctrl_pkg::*;

    logic [ROWS-1:0]    row_req_i;
    logic [COLS-1:0]    col_req_i;
    logic [ROWS-1:0]    row_sel_o;
    logic [COLS-1:0]    col_ack_o;
    logic               ev_valid_o;
    logic               ev_ready_i;
    logic [X_WIDTH-1:0] ev_x_o;
    logic [Y_WIDTH-1:0] ev_y_o;

    modport master (
        input  row_req_i, col_req_i, ev_ready_i,
        output row_sel_o, col_ack_o, ev_valid_o, ev_x_o, ev_y_o
    );

    modport slave (
        output row_req_i, col_req_i, ev_ready_i,
        input  row_sel_o, col_ack_o, ev_valid_o, ev_x_o, ev_y_o
    );

endinterface

// File: rtl/ebc_readout_ctrl_rr_pick.sv
// rtl/ebc_readout_ctrl_rr_pick.sv - first set request bit at or after a pointer, wrapping
module ebc_readout_ctrl_rr_pick #(
    parameter int WIDTH = 8,
    parameter int IW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             found,
    output logic [WIDTH-1:0] onehot,
    output logic [IW-1:0]    index
);

    always_comb begin
        logic [IW-1:0] pos;
        pos    = '0;
        found  = 1'b0;
        onehot = '0;
        index  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pos = IW'((int'(ptr) + i) % WIDTH);
            if (!found && req[pos]) begin
                found       = 1'b1;
                onehot[pos] = 1'b1;
                index       = pos;
            end
        end
    end

endmodule

// File: rtl/ebc_readout_ctrl.sv
// rtl/ebc_readout_ctrl.sv - round-robin row readout sequencer emitting (x,y) address events
module ebc_readout_ctrl
    import ebc_readout_ctrl_pkg::*;
#(
    parameter int SETTLE_CYC = 2
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              enable_i,
    output logic              busy_o,
    ebc_readout_ctrl_if.master bus
);

    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    ebc_rd_state_t      state;
    logic [Y_WIDTH-1:0] row_ptr;
    logic [COLS-1:0]    served;
    logic [CW-1:0]      settle_cnt;
    logic               row_found;
    logic [ROWS-1:0]    row_onehot;
    logic [Y_WIDTH-1:0] row_idx;
    logic [COLS-1:0]    pend;

    ebc_readout_ctrl_rr_pick #(.WIDTH(ROWS)) u_row_pick (
        .req    (bus.row_req_i),
        .ptr    (row_ptr),
        .found  (row_found),
        .onehot (row_onehot),
        .index  (row_idx)
    );

    // Columns already acknowledged in this row visit are masked so a pixel
    // that re-asserts before the row is released is not read twice.
    assign pend = bus.col_req_i & ~served;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state          <= ST_IDLE;
            row_ptr        <= '0;
            served         <= '0;
            settle_cnt     <= '0;
            busy_o         <= 1'b0;
            bus.row_sel_o  <= '0;
            bus.col_ack_o  <= '0;
            bus.ev_valid_o <= 1'b0;
            bus.ev_x_o     <= '0;
            bus.ev_y_o     <= '0;
        end else begin
            bus.col_ack_o <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (enable_i && row_found) begin
                        bus.row_sel_o <= row_onehot;
                        bus.ev_y_o    <= row_idx;
                        served        <= '0;
                        settle_cnt    <= '0;
                        busy_o        <= 1'b1;
                        state         <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == CW'(SETTLE_CYC - 1)) begin
                        state <= ST_SCAN;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_SCAN: begin
                    // Once raised, valid and the address hold until the handshake.
                    if (bus.ev_valid_o) begin
                        if (bus.ev_ready_i) begin
                            bus.ev_valid_o     <= 1'b0;
                            bus.col_ack_o      <= COLS'(1) << bus.ev_x_o;
                            served[bus.ev_x_o] <= 1'b1;
                            state              <= ST_ACK;
                        end
                    end else if (pend == '0) begin
                        state <= ST_DONE;
                    end else begin
                        bus.ev_valid_o <= 1'b1;
                        bus.ev_x_o     <= lowest_col(pend);
                    end
                end
                ST_ACK: begin
                    state <= ST_SCAN;
                end
                ST_DONE: begin
                    bus.row_sel_o <= '0;
                    row_ptr       <= (int'(bus.ev_y_o) == ROWS - 1) ? '0 : bus.ev_y_o + 1'b1;
                    busy_o        <= 1'b0;
                    state         <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ebc_readout_ctrl.sv
// tb/tb_ebc_readout_ctrl.sv - scoreboard bench for the event readout sequencer
module tb_ebc_readout_ctrl;

    typedef struct {
        int x;
        int y;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       busy;
    logic [7:0] pix [8];
    logic       reraise = 1'b0;
    int         ready_mode = 0;
    int         ptr_m = 0;
    int         hs_cnt = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    ev_t        q [$];

    ebc_readout_ctrl_if bus ();

    ebc_readout_ctrl #(.SETTLE_CYC(2)) dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .enable_i (enable),
        .busy_o   (busy),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Pixel array: a row requests while any of its pixels holds an event;
    // the selected row presents its pixels on the column lines.
    always_comb begin
        bus.row_req_i = '0;
        bus.col_req_i = '0;
        for (int r = 0; r < 8; r++) begin
            bus.row_req_i[r] = |pix[r];
            if (bus.row_sel_o[r]) bus.col_req_i = pix[r];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_check(input string name, input int n, input int limit);
        n_chk++;
        if (n >= limit) begin
            n_fail++;
            $display("FAIL %s: waited %0d cycles, required fewer than %0d", name, n, limit);
        end
    endtask

    function automatic int sel_idx();
        int r = -1;
        for (int i = 0; i < 8; i++) if (bus.row_sel_o[i]) r = i;
        return r;
    endfunction

    function automatic int next_row(input logic [7:0] m [8], input int p);
        for (int i = 0; i < 8; i++) begin
            if (m[(p + i) % 8] != 8'h00) return (p + i) % 8;
        end
        return -1;
    endfunction

    task automatic push_row(input int r);
        for (int c = 0; c < 8; c++) if (pix[r][c]) q.push_back(ev_t'{x: c, y: r});
    endtask

    // Every pending pixel drains: rows in round-robin order from the pointer,
    // each row's columns lowest first.
    task automatic push_all();
        logic [7:0] m [8];
        int r;
        for (int i = 0; i < 8; i++) m[i] = pix[i];
        r = next_row(m, ptr_m);
        while (r >= 0) begin
            for (int c = 0; c < 8; c++) if (m[r][c]) q.push_back(ev_t'{x: c, y: r});
            m[r] = 8'h00;
            ptr_m = (r + 1) % 8;
            r = next_row(m, ptr_m);
        end
    endtask

    task automatic clear_pix();
        for (int i = 0; i < 8; i++) pix[i] = 8'h00;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        timeout_check(name, n, 3000);
    endtask

    task automatic wait_hs(input string name, input int target);
        int n = 0;
        while (hs_cnt < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        timeout_check(name, n, 2000);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!bus.ev_valid_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        timeout_check(name, n, 200);
    endtask

    task automatic ready_loop();
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.ev_ready_i = 1'b1;
                1:       bus.ev_ready_i = 1'($urandom_range(0, 1));
                default: bus.ev_ready_i = 1'b0;
            endcase
        end
    endtask

    task automatic monitor_loop();
        logic ack_due = 1'b0;
        int   ack_x = 0;
        logic prev_wait = 1'b0;
        int   px = 0;
        int   py = 0;
        int   r;
        ev_t  e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ack_due   = 1'b0;
                prev_wait = 1'b0;
            end else begin
                check("col_ack", 32'(bus.col_ack_o), ack_due ? (32'd1 << ack_x) : 32'd0);
                if (bus.col_ack_o != 8'h00 && !reraise) begin
                    r = sel_idx();
                    if (r >= 0) pix[r] = pix[r] & ~bus.col_ack_o;
                end
                if (prev_wait) begin
                    check("hold_valid", 32'(bus.ev_valid_o), 32'd1);
                    check("hold_x", 32'(bus.ev_x_o), 32'(px));
                    check("hold_y", 32'(bus.ev_y_o), 32'(py));
                end
                ack_due = 1'b0;
                if (bus.ev_valid_o && bus.ev_ready_i) begin
                    if (q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_event: got x=%0d y=%0d, required no event", bus.ev_x_o, bus.ev_y_o);
                    end else begin
                        e = q.pop_front();
                        check("ev_x", 32'(bus.ev_x_o), 32'(e.x));
                        check("ev_y", 32'(bus.ev_y_o), 32'(e.y));
                        check("row_sel_at_event", 32'(bus.row_sel_o), 32'd1 << e.y);
                    end
                    ack_due = 1'b1;
                    ack_x   = int'(bus.ev_x_o);
                    hs_cnt++;
                end
                prev_wait = bus.ev_valid_o && !bus.ev_ready_i;
                px = int'(bus.ev_x_o);
                py = int'(bus.ev_y_o);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_row_sel"}, 32'(bus.row_sel_o), 32'd0);
        check({tag, "_col_ack"}, 32'(bus.col_ack_o), 32'd0);
        check({tag, "_ev_valid"}, 32'(bus.ev_valid_o), 32'd0);
        check({tag, "_ev_x"}, 32'(bus.ev_x_o), 32'd0);
        check({tag, "_ev_y"}, 32'(bus.ev_y_o), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int r;
        bus.ev_ready_i = 1'b1;
        clear_pix();
        fork
            monitor_loop();
            ready_loop();
        join_none

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Round-robin across rows 0,1,4,7 with column 0 re-raised after every ack.
        reraise = 1'b1;
        pix[0] = 8'h01; pix[1] = 8'h01; pix[4] = 8'h01; pix[7] = 8'h01;
        begin
            logic [7:0] m [8];
            for (int i = 0; i < 8; i++) m[i] = pix[i];
            for (int k = 0; k < 6; k++) begin
                r = next_row(m, ptr_m);
                q.push_back(ev_t'{x: 0, y: r});
                ptr_m = (r + 1) % 8;
            end
        end
        base = hs_cnt;
        enable = 1'b1;
        wait_hs("rr_six_events", base + 6);
        enable = 1'b0;
        wait_drain("rr_drain");
        reraise = 1'b0;
        clear_pix();
        @(negedge clk);

        // Row 2, columns 0,2,7, all held high after ack; stall the x=2 event.
        reraise = 1'b1;
        pix[2] = 8'h85;
        push_all();
        base = hs_cnt;
        enable = 1'b1;
        wait_hs("multi_first", base + 1);
        enable = 1'b0;
        ready_mode = 2;
        wait_valid("stall_valid");
        check("stall_x", 32'(bus.ev_x_o), 32'd2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid_held", 32'(bus.ev_valid_o), 32'd1);
            check("stall_x_held", 32'(bus.ev_x_o), 32'd2);
            check("stall_y_held", 32'(bus.ev_y_o), 32'd2);
            check("stall_no_ack", 32'(bus.col_ack_o), 32'd0);
        end
        ready_mode = 0;
        wait_drain("multi_drain");
        reraise = 1'b0;
        clear_pix();
        @(negedge clk);

        // Single pixel x=5 y=3 with latency checks.
        enable = 1'b1;
        pix[3] = 8'h20;
        push_all();
        @(negedge clk);
        check("lat_row_sel", 32'(bus.row_sel_o), 32'h08);
        check("lat_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("lat_valid_s1", 32'(bus.ev_valid_o), 32'd0);
        @(negedge clk);
        check("lat_valid_s2", 32'(bus.ev_valid_o), 32'd0);
        @(negedge clk);
        check("lat_valid_on", 32'(bus.ev_valid_o), 32'd1);
        wait_drain("single_drain");
        check("single_row_sel_off", 32'(bus.row_sel_o), 32'd0);
        check("single_busy_off", 32'(busy), 32'd0);
        enable = 1'b0;
        @(negedge clk);

        // Enable dropped mid-row: the granted row finishes, no further row starts.
        pix[5] = 8'h2C; pix[6] = 8'h01; pix[1] = 8'h10;
        r = next_row(pix, ptr_m);
        push_row(r);
        ptr_m = (r + 1) % 8;
        enable = 1'b1;
        wait_valid("en_low_valid");
        enable = 1'b0;
        wait_drain("en_low_drain");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("en_low_idle_busy", 32'(busy), 32'd0);
            check("en_low_idle_row_sel", 32'(bus.row_sel_o), 32'd0);
        end
        clear_pix();
        @(negedge clk);

        // Random pixel patterns with random downstream backpressure.
        ready_mode = 1;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 8; i++) pix[i] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            push_all();
            enable = 1'b1;
            wait_drain("rand_drain");
            enable = 1'b0;
            clear_pix();
            @(negedge clk);
        end
        ready_mode = 0;

        // Reset while an event is outstanding.
        pix[3] = 8'hFF; pix[6] = 8'h0F;
        push_all();
        base = hs_cnt;
        enable = 1'b1;
        wait_hs("pre_reset_events", base + 2);
        wait_valid("pre_reset_valid");
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("mid_reset");
        q.delete();
        clear_pix();
        enable = 1'b0;
        ptr_m = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Pointer restarts at row 0 after reset.
        pix[0] = 8'h02; pix[7] = 8'h40;
        push_all();
        enable = 1'b1;
        wait_drain("post_reset_drain");
        enable = 1'b0;
        check("queue_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
